ped_crossing_sched: RTL and testbench
=====================================

# ped_crossing_sched

Pedestrian-crossing scheduler that sits beside the intersection traffic-light controller. It latches the three pedestrian push-buttons, one per approach group (0 = WE, 1 = EW, 2 = NS/SN). It asks the traffic controller to hold all-red through a hold/all_red handshake, and grants the walk interval to one approach at a time in round-robin order. All intervals are counted in `tick` pulses from the shared clock divider.

## Interface
- `WALK_T`, default 10: ticks of steady walk.
- `FLASH_T`, default 6: ticks of flashing walk.
- `CLEAR_T`, default 2: ticks of don't-walk before hold is released. Each of these parameters is 1..31.
- `clk` in, 1: system clock. One clock domain.
- `rst_n` in, 1: reset. Asynchronous, active-low.
- `tick` in, 1: one-`clk`-wide time-base enable (2 Hz on the board).
- `btn` in, 3: raw pedestrian buttons, active-high, asynchronous to `clk`.
- `all_red` in, 1: high while the traffic controller drives every signal red.
- `hold` out, 1: asks the traffic controller to stay in all-red.
- `walk` out, 3: walk lamp per approach, active-high.
- `dont_walk` out, 3: don't-walk lamp per approach, active-high.
- `pend` out, 3: latched, not-yet-served requests.
- `busy` out, 1: high in any state other than IDLE.
- `err` out, 1: sticky protocol fault.

## Operation
- Input conditioning:
  - `btn` passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge sets `pend[i]`. The bit stays set until that approach is granted.
- Arbitration:
  - The 2-bit pointer `ptr` names the highest-priority approach.
  - Grant `g` is the first set `pend` bit searching `ptr`, `ptr+1`, … with wrap mod 3.
  - On grant: `pend[g]` clears and `ptr` becomes (g+1) mod 3. Value 3 is never used.
- States:
  - IDLE: `hold`=0. Goes to WAIT_RED when `pend`≠0.
  - WAIT_RED: `hold`=1. When `all_red`=1, latch `g`, clear `pend[g]`, zero the tick counter, go to WALK.
  - WALK: `walk[g]`=1, `dont_walk[g]`=0. On the tick where the counter = WALK_T−1, zero the counter and go to FLASH.
  - FLASH: `walk[g]` starts at 1 and toggles on every tick. `dont_walk[g]`=0. At count FLASH_T−1 (on a tick), go to CLEAR.
  - CLEAR: all `dont_walk`=1, `walk`=0. At count CLEAR_T−1 (on a tick), go to COOLDOWN.
  - COOLDOWN: `hold`=0. Goes to IDLE once `all_red`=0 has been sampled, so vehicles always get a green between pedestrian phases.
- In every state, approaches that are not granted show `walk`=0 and `dont_walk`=1.
- Fault: if `all_red`=0 is sampled in WALK or FLASH:
  - go to CLEAR immediately and restart its counter;
  - set `err`=1, which holds until reset.
- Simultaneous events:
  - An edge on `btn[g]` in the grant cycle, or at any time during WALK/FLASH, is discarded.
  - From CLEAR onward, edges latch normally.
  - Edges on other approaches always latch, in every state.
- Tick counter: 5 bits, advances only on `tick`. It never wraps because every parameter is ≤31.

## Timing
- Reset values: state=IDLE, `pend`=000, `ptr`=0, `hold`=0, `walk`=000, `dont_walk`=111, `busy`=0, `err`=0. All outputs are registered.
- Button latency: `btn` first sampled high at edge N gives `pend[i]`=1 after edge N+3.
- Hold latency: `hold`=1 after edge N+4, when the request arrives in IDLE.
- Grant latency: `all_red`=1 sampled at edge M (in WAIT_RED) gives `walk[g]`=1 and the `pend[g]` clear after edge M.
- Phase lengths: WALK lasts exactly WALK_T ticks, FLASH lasts FLASH_T ticks, CLEAR lasts CLEAR_T ticks.
- `hold` falls on the transition into COOLDOWN.
- `rst_n` low during any phase forces the reset values asynchronously. Any phase in progress is abandoned.
- `tick` and a state transition in the same cycle: the transition takes effect. A tick is never counted twice.

## Test plan
Bench parameters: WALK_T=4, FLASH_T=2, CLEAR_T=1; `tick` every 4 clocks.
- Single request: pulse `btn`=001, hold `all_red`=1 → `pend`=001 after 3 clocks, `hold`=1, then:
  - `walk`=001 for 4 ticks, toggles 1,0 over 2 ticks;
  - `dont_walk`=111 for 1 tick;
  - `hold`=0, `pend`=000.
- Round-robin with `btn`=111 at once, `ptr`=0:
  - grants 0 then 1 then 2, one per all-red window;
  - the bench drops `all_red` during each COOLDOWN;
  - `ptr` ends at 0.
- Re-press during service: `btn[0]` pulsed during WALK of approach 0 → `pend[0]` stays 0. Pulsed during CLEAR → `pend[0]`=1.
- Fault: `all_red` dropped in mid-WALK → next clock in CLEAR, `walk`=000, `err`=1. `err` stays 1 until `rst_n`.
- Delayed handshake: request with `all_red`=0 for 20 clocks → `hold`=1, `walk`=000 throughout. Walk starts 1 clock after `all_red` rises.
- Async reset in FLASH → outputs return to reset values without waiting for a `clk` edge, `pend`=000.

Source files
------------

// File: rtl/ped_crossing_sched_if.sv
// Signal bundle shared by the pedestrian scheduler, the button/time-base side
// and the traffic-light controller handshake.
interface ped_crossing_sched_if;
   logic       tick;
   logic [2:0] btn;
   logic       all_red;
   logic       hold;
   logic [2:0] walk;
   logic [2:0] dont_walk;
   logic [2:0] pend;
   logic       busy;
   logic       err;

   modport master (
      output tick, btn, all_red,
      input  hold, walk, dont_walk, pend, busy, err
   );

   modport slave (
      input  tick, btn, all_red,
      output hold, walk, dont_walk, pend, busy, err
   );
endinterface

// File: rtl/ped_crossing_sched.sv
// Pedestrian-crossing scheduler: latches push-button requests, holds the
// intersection in all-red and grants walk intervals round-robin.
module ped_crossing_sched #(
   parameter int WALK_T  = 10,
   parameter int FLASH_T = 6,
   parameter int CLEAR_T = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   ped_crossing_sched_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RED,
      WALK,
      FLASH,
      CLEAR,
      COOLDOWN
   } state_t;

   localparam logic [4:0] WALK_LAST  = 5'(WALK_T - 1);
   localparam logic [4:0] FLASH_LAST = 5'(FLASH_T - 1);
   localparam logic [4:0] CLEAR_LAST = 5'(CLEAR_T - 1);

   state_t     r_state;
   logic [2:0] r_btnMeta;
   logic [2:0] r_btnSync;
   logic [2:0] r_btnPrev;
   logic [2:0] r_btnEdge;
   logic [2:0] r_pend;
   logic [1:0] r_ptr;
   logic [1:0] r_grant;
   logic [4:0] r_cnt;
   logic       r_hold;
   logic [2:0] r_walk;
   logic [2:0] r_dontWalk;
   logic       r_busy;
   logic       r_err;

   logic [1:0] w_grant;
   logic [2:0] w_grantOneHot;
   logic [2:0] w_servedOneHot;
   logic [1:0] w_nextPtr;
   logic       w_grantNow;
   logic [2:0] w_discard;
   logic [2:0] w_pendNext;

   // Two-flop synchronizer followed by a registered rising-edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btnMeta <= 3'b000;
         r_btnSync <= 3'b000;
         r_btnPrev <= 3'b000;
         r_btnEdge <= 3'b000;
      end else begin
         r_btnMeta <= bus.btn;
         r_btnSync <= r_btnMeta;
         r_btnPrev <= r_btnSync;
         r_btnEdge <= r_btnSync & ~r_btnPrev;
      end
   end

   // Round-robin search starting at the pointer, wrapping modulo three.
   always_comb begin
      w_grant = 2'd0;
      case (r_ptr)
         2'd1: begin
            if (r_pend[1])      w_grant = 2'd1;
            else if (r_pend[2]) w_grant = 2'd2;
            else                w_grant = 2'd0;
         end
         2'd2: begin
            if (r_pend[2])      w_grant = 2'd2;
            else if (r_pend[0]) w_grant = 2'd0;
            else                w_grant = 2'd1;
         end
         default: begin
            if (r_pend[0])      w_grant = 2'd0;
            else if (r_pend[1]) w_grant = 2'd1;
            else                w_grant = 2'd2;
         end
      endcase
   end

   assign w_grantOneHot  = 3'(3'b001 << w_grant);
   assign w_servedOneHot = 3'(3'b001 << r_grant);
   assign w_nextPtr      = (w_grant == 2'd2) ? 2'd0 : w_grant + 2'd1;
   assign w_grantNow     = (r_state == WAIT_RED) && bus.all_red;

   // A re-press of the approach being served is dropped until its clearance starts.
   always_comb begin
      w_discard = 3'b000;
      if (w_grantNow)
         w_discard = w_grantOneHot;
      else if ((r_state == WALK) || (r_state == FLASH))
         w_discard = w_servedOneHot;
   end

   assign w_pendNext = (r_pend & ~(w_grantNow ? w_grantOneHot : 3'b000))
                     | (r_btnEdge & ~w_discard);

   // Sequencer with registered lamp, hold and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pend     <= 3'b000;
         r_ptr      <= 2'd0;
         r_grant    <= 2'd0;
         r_cnt      <= 5'd0;
         r_hold     <= 1'b0;
         r_walk     <= 3'b000;
         r_dontWalk <= 3'b111;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_pend <= w_pendNext;
         case (r_state)
            IDLE: begin
               if (r_pend != 3'b000) begin
                  r_state <= WAIT_RED;
                  r_hold  <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            WAIT_RED: begin
               if (bus.all_red) begin
                  r_state    <= WALK;
                  r_grant    <= w_grant;
                  r_ptr      <= w_nextPtr;
                  r_cnt      <= 5'd0;
                  r_walk     <= w_grantOneHot;
                  r_dontWalk <= ~w_grantOneHot;
               end
            end
            WALK: begin
               if (!bus.all_red) begin
                  r_state    <= CLEAR;
                  r_cnt      <= 5'd0;
                  r_walk     <= 3'b000;
                  r_dontWalk <= 3'b111;
                  r_err      <= 1'b1;
               end else if (bus.tick) begin
                  if (r_cnt == WALK_LAST) begin
                     r_state <= FLASH;
                     r_cnt   <= 5'd0;
                  end else begin
                     r_cnt <= r_cnt + 5'd1;
                  end
               end
            end
            FLASH: begin
               if (!bus.all_red) begin
                  r_state    <= CLEAR;
                  r_cnt      <= 5'd0;
                  r_walk     <= 3'b000;
                  r_dontWalk <= 3'b111;
                  r_err      <= 1'b1;
               end else if (bus.tick) begin
                  if (r_cnt == FLASH_LAST) begin
                     r_state    <= CLEAR;
                     r_cnt      <= 5'd0;
                     r_walk     <= 3'b000;
                     r_dontWalk <= 3'b111;
                  end else begin
                     r_cnt  <= r_cnt + 5'd1;
                     r_walk <= r_walk ^ w_servedOneHot;
                  end
               end
            end
            CLEAR: begin
               if (bus.tick) begin
                  if (r_cnt == CLEAR_LAST) begin
                     r_state <= COOLDOWN;
                     r_cnt   <= 5'd0;
                     r_hold  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 5'd1;
                  end
               end
            end
            COOLDOWN: begin
               // Vehicles must see a green before the next pedestrian phase.
               if (!bus.all_red) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_hold     <= 1'b0;
               r_walk     <= 3'b000;
               r_dontWalk <= 3'b111;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hold      = r_hold;
   assign bus.walk      = r_walk;
   assign bus.dont_walk = r_dontWalk;
   assign bus.pend      = r_pend;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_ped_crossing_sched.sv
// Randomized bench for ped_crossing_sched, checked against a phase-duration
// and round-robin model of the crossing rules.
`timescale 1ns/1ps
module tb_ped_crossing_sched;

   localparam int W = 4;
   localparam int F = 2;
   localparam int C = 1;

   logic clk = 1'b0;
   logic rst_n;

   ped_crossing_sched_if pif();

   ped_crossing_sched #(
      .WALK_T (W),
      .FLASH_T(F),
      .CLEAR_T(C)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (pif)
   );

   always #5 clk = ~clk;

   int         checkCount;
   int         failCount;
   int         tickPhase;
   logic [2:0] expPend;
   int         expPtr;
   logic       expErr;

   // One tick pulse every four clocks, changed just after the rising edge.
   initial begin
      tickPhase = 0;
      pif.tick  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tickPhase = (tickPhase + 1) % 4;
         pif.tick  = (tickPhase == 0);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // First pending approach at or after the pointer, wrapping modulo three.
   function automatic int nextGrant(input logic [2:0] p, input int ptr);
      for (int i = 0; i < 3; i++) begin
         if (p[(ptr + i) % 3]) return (ptr + i) % 3;
      end
      return 0;
   endfunction

   // 0 walk, 1 flash, 2 clear, 3 cooldown, from ticks since grant / since fault.
   function automatic int phaseOf(input int k, input int fk);
      if (fk >= 0) return (fk < C) ? 2 : 3;
      if (k < W) return 0;
      if (k < W + F) return 1;
      if (k < W + F + C) return 2;
      return 3;
   endfunction

   // Expected {hold, walk, dont_walk}.
   function automatic logic [6:0] expLamps(input int g, input int k, input int fk);
      logic [2:0] one;
      int ph;
      one = 3'(1 << g);
      ph  = phaseOf(k, fk);
      case (ph)
         0:       return {1'b1, one, ~one};
         1:       return (((k - W) % 2) == 0) ? {1'b1, one, ~one} : {1'b1, 3'b000, ~one};
         2:       return {1'b1, 3'b000, 3'b111};
         default: return {1'b0, 3'b000, 3'b111};
      endcase
   endfunction

   task automatic applyStimulus(input logic [2:0] mask);
      @(negedge clk);
      pif.btn = mask;
      repeat (2) @(negedge clk);
      pif.btn = 3'b000;
      repeat (2) @(negedge clk);
      expPend = expPend | mask;
      checkOutput("pendLatch", 32'(pif.pend), 32'(expPend));
   endtask

   // One all-red window: wait for hold, optionally delay all_red, then follow the phases.
   task automatic serveWindow(input int delay, input int dropK, input int pressK, input int pressIdx,
                              input bit pressClear, input bit resetInFlash);
      int         g;
      int         k;
      int         fk;
      int         ph;
      int         btnLeft;
      int         guard;
      bit         dropped;
      bit         pressedWalk;
      bit         pressedClear;
      logic [2:0] one;

      g   = nextGrant(expPend, expPtr);
      one = 3'(1 << g);
      guard = 0;
      while ((pif.hold !== 1'b1) && (guard < 50)) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("holdRaised", 32'(pif.hold), 32'(1));
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         checkOutput("waitRed", 32'({pif.hold, pif.walk}), 32'({1'b1, 3'b000}));
      end
      pif.all_red = 1'b1;
      @(negedge clk);
      checkOutput("grantWalk", 32'(pif.walk), 32'(one));
      expPend[g] = 1'b0;
      expPtr     = (g + 1) % 3;
      checkOutput("grantPend", 32'(pif.pend), 32'(expPend));

      k = 0;
      fk = -1;
      btnLeft = 0;
      dropped = 1'b0;
      pressedWalk = 1'b0;
      pressedClear = 1'b0;
      for (guard = 0; guard < 300; guard++) begin
         @(posedge clk);
         if (dropped && (fk < 0)) fk = 0;
         else if (pif.tick === 1'b1) begin
            if (fk >= 0) fk++;
            else k++;
         end
         @(negedge clk);
         checkOutput("lamps", 32'({pif.hold, pif.walk, pif.dont_walk}), 32'(expLamps(g, k, fk)));
         if (fk >= 0) checkOutput("faultErr", 32'(pif.err), 32'(expErr));
         ph = phaseOf(k, fk);
         if (btnLeft > 0) begin
            btnLeft--;
            if (btnLeft == 0) pif.btn = 3'b000;
         end
         if ((ph == 0) && (k == pressK) && !pressedWalk) begin
            pif.btn[pressIdx] = 1'b1;
            btnLeft = 2;
            pressedWalk = 1'b1;
            if (pressIdx != g) expPend[pressIdx] = 1'b1;
         end
         if ((ph == 2) && pressClear && !pressedClear) begin
            pif.btn[g] = 1'b1;
            btnLeft = 2;
            pressedClear = 1'b1;
            expPend[g] = 1'b1;
         end
         if ((ph == 0) && (k == dropK) && !dropped) begin
            pif.all_red = 1'b0;
            dropped = 1'b1;
            expErr = 1'b1;
         end
         if ((ph == 1) && resetInFlash) begin
            checkOutput("pendBeforeRst", 32'(pif.pend), 32'(expPend));
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("rstAsync", 32'({pif.hold, pif.walk, pif.dont_walk, pif.busy, pif.err}),
                        32'({1'b0, 3'b000, 3'b111, 1'b0, 1'b0}));
            pif.btn = 3'b000;
            pif.all_red = 1'b0;
            expPend = 3'b000;
            expPtr = 0;
            expErr = 1'b0;
            checkOutput("rstPend", 32'(pif.pend), 32'(expPend));
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (ph == 3) break;
      end
      if (guard >= 300) checkOutput("phaseTimeout", 32'(0), 32'(1));

      pif.all_red = 1'b0;
      pif.btn = 3'b000;
      @(negedge clk);
      checkOutput("idleAfterCool", 32'({pif.busy, pif.hold}), 32'(2'b00));
      checkOutput("errFlag", 32'(pif.err), 32'(expErr));
      checkOutput("pendAfter", 32'(pif.pend), 32'(expPend));
   endtask

   initial begin
      int guardWin;
      int pk;
      checkCount  = 0;
      failCount   = 0;
      rst_n       = 1'b0;
      pif.btn     = 3'b000;
      pif.all_red = 1'b0;
      expPend     = 3'b000;
      expPtr      = 0;
      expErr      = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetState",
                  32'({pif.hold, pif.walk, pif.dont_walk, pif.pend, pif.busy, pif.err}),
                  32'({1'b0, 3'b000, 3'b111, expPend, 1'b0, expErr}));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] round-robin over all three approaches");
      applyStimulus(3'b111);
      for (int i = 0; i < 3; i++) serveWindow(2, -1, -1, 0, 1'b0, 1'b0);
      applyStimulus(3'b011);
      for (int i = 0; i < 2; i++) serveWindow(1, -1, -1, 0, 1'b0, 1'b0);

      $display("[TB] single request with latency checks");
      @(negedge clk);
      pif.btn = 3'b001;
      @(negedge clk);
      @(negedge clk);
      pif.btn = 3'b000;
      @(negedge clk);
      checkOutput("pendLatencyEarly", 32'(pif.pend), 32'(expPend));
      expPend = expPend | 3'b001;
      @(negedge clk);
      checkOutput("pendLatency", 32'(pif.pend), 32'(expPend));
      checkOutput("holdBefore", 32'(pif.hold), 32'(0));
      @(negedge clk);
      checkOutput("holdLatency", 32'({pif.hold, pif.busy}), 32'(2'b11));
      serveWindow(0, -1, -1, 0, 1'b0, 1'b0);

      $display("[TB] re-press during walk and during clear");
      applyStimulus(3'b001);
      serveWindow(1, -1, 1, 0, 1'b1, 1'b0);

      $display("[TB] all_red dropped in mid-walk");
      serveWindow(3, 2, -1, 0, 1'b0, 1'b0);
      applyStimulus(3'b100);
      serveWindow(1, -1, -1, 0, 1'b0, 1'b0);

      $display("[TB] delayed all_red handshake");
      applyStimulus(3'b010);
      serveWindow(20, -1, -1, 0, 1'b0, 1'b0);

      $display("[TB] asynchronous reset during flash");
      applyStimulus(3'b001);
      serveWindow(1, -1, 1, 2, 1'b0, 1'b1);
      repeat (2) @(negedge clk);

      $display("[TB] randomized rounds");
      for (int r = 0; r < 6; r++) begin
         applyStimulus(3'($urandom_range(1, 7)));
         guardWin = 0;
         while ((expPend != 3'b000) && (guardWin < 12)) begin
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
            serveWindow(int'($urandom_range(0, 5)), -1, pk, int'($urandom_range(0, 2)), 1'b0, 1'b0);
            guardWin++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
